pipelined_block_subtractor: RTL and testbench
=============================================

Name: pipelined_block_subtractor

Overview:
- Computes d = a - b on NBIT operands as an NBIT_BLOCK-wide slice-per-stage pipeline.
- Each stage resolves one block slice, and the inter-block carry is registered between stages.
- This is the subtract-side counterpart of the team's block carry-lookahead adder, for datapaths that need a short critical path.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- NBIT, 32, operand and result width.
- NBIT_BLOCK, 4, slice width per pipeline stage. NBIT must be divisible by NBIT_BLOCK; an elaboration-time error is raised otherwise.
- BLOCK_NUM (localparam), NBIT/NBIT_BLOCK, number of stages, which equals the latency.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operand pair a/b is valid
- in_ready  output  1  block accepts operands this cycle
- a  input  NBIT  minuend
- b  input  NBIT  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- d  output  NBIT  a - b mod 2^NBIT
- borrow  output  1  1 when a < b unsigned (inverted final carry)

Behaviour:
- Arithmetic
  - Each slice computes a_slice + ~b_slice + cin with ripple or lookahead inside the slice.
  - cin is 1 for slice 0; slice k's cin is the registered carry-out of slice k-1.
  - borrow = ~carry_out of slice BLOCK_NUM-1.
- Pipeline structure
  - Stage k register holds: valid bit, the computed result slices 0..k, the unprocessed operand slices k+1..BLOCK_NUM-1, and the carry out of slice k.
  - No mixing between transactions.
- Advance and handshake
  - Global advance = ~out_valid | out_ready. All stages shift together when advance=1 and hold when advance=0.
  - in_ready = advance, combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
  - Transfer in occurs when in_valid & in_ready. Stage 0 valid loads in_valid when advance=1.
  - Bubbles propagate as valid=0 stages. Bubbles are not compressed.
- Latency and throughput
  - Latency is BLOCK_NUM cycles from accepted input to out_valid=1.
  - Throughput is 1 per cycle while out_ready=1.
- Output stability
  - out_valid, d and borrow are driven directly from the last stage register.
  - While out_valid=1 and out_ready=0, d and borrow stay stable and out_valid stays 1.
- Reset
  - All valid bits go to 0, so out_valid=0, d=0 and borrow=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight transaction. No result for those transactions ever appears.
- Simultaneous events
  - In-flow and out-flow in the same cycle are both legal at full occupancy when out_ready=1.
  - in_valid with advance=0 is not accepted. The producer must hold a/b.
- BLOCK_NUM=1 degenerates to a single registered subtractor with latency 1.

Optional Feature:
- Macro: PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN.
- When defined, two extra outputs are present:
  - ovf (1 bit): signed overflow, a[NBIT-1] != b[NBIT-1] and d[NBIT-1] != a[NBIT-1].
  - zero (1 bit): d == 0.
- Both flags are registered in the last stage, aligned with d, reset to 0, and held under stall like d.
- Computing ovf requires carrying a[NBIT-1] and b[NBIT-1] through the pipeline.
- When the macro is undefined, the ports and the related logic are absent. The other behaviour is identical.

Test Plan:
- Basic subtract (defaults NBIT=32, NBIT_BLOCK=4): a=0x0000_0010, b=0x0000_0001, out_ready=1 -> out_valid exactly 8 cycles after acceptance, d=0x0000_000F, borrow=0.
- Full-width carry chain: a=0x0000_0000, b=0x0000_0001 -> d=0xFFFF_FFFF, borrow=1; with FLAGS_EN, ovf=0 and zero=0.
- Signed overflow, FLAGS_EN: a=0x8000_0000, b=0x0000_0001 -> d=0x7FFF_FFFF, borrow=0, ovf=1. Then a=b=0x1234_5678 -> d=0, zero=1.
- Back-to-back with stall:
  - Stimulus: 20 random pairs streamed with in_valid=1 continuously, and out_ready held 0 for 5 cycles midway.
  - Response: in_ready=0 during the stall, outputs held stable, all 20 results in order and equal to reference a-b, no loss or duplication.
- Reset mid-flight: assert reset for 1 cycle with 5 transactions in flight -> out_valid=0 next cycle and no stale result afterwards; the next accepted pair emerges after exactly 8 cycles.
- Parameter sweep: NBIT=8 with NBIT_BLOCK in {1,2,4,8}, exhaustive a,b -> d and borrow match the reference model, latency = 8/NBIT_BLOCK.

Source files
------------

// File: rtl/pipelined_block_subtractor_if.sv
// pipelined_block_subtractor_if
//   Operand/result bus of the pipelined block subtractor.
//   Producer side: in_valid, in_ready, a (minuend), b (subtrahend).
//   Consumer side: out_valid, out_ready, d (a - b), borrow (a < b unsigned).
//   With PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN defined the consumer side also
//   carries ovf (signed overflow) and zero (d == 0).
//   modport slave  : subtractor view
//   modport master : producer/consumer view
interface pipelined_block_subtractor_if #(
  parameter int NBIT = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] d;
  logic            borrow;
`ifdef PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN
  logic            ovf;
  logic            zero;

  modport slave  (input in_valid, a, b, out_ready,
                  output in_ready, out_valid, d, borrow, ovf, zero);
  modport master (output in_valid, a, b, out_ready,
                  input in_ready, out_valid, d, borrow, ovf, zero);
`else
  modport slave  (input in_valid, a, b, out_ready,
                  output in_ready, out_valid, d, borrow);
  modport master (output in_valid, a, b, out_ready,
                  input in_ready, out_valid, d, borrow);
`endif
endinterface

// File: rtl/pipelined_block_subtractor.sv
// pipelined_block_subtractor
//   d = a - b (mod 2^NBIT), one NBIT_BLOCK-wide slice resolved per stage,
//   inter-slice carry registered between stages. Latency BLOCK_NUM cycles,
//   one result per cycle while the consumer is ready.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high; flushes every in-flight transaction
//     bus    : pipelined_block_subtractor_if.slave (valid/ready in and out)
//   Optional: PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN adds registered ovf/zero
//   outputs aligned with d.

// One slice: a + ~b + cin.
module pbs_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
endmodule

module pipelined_block_subtractor #(
  parameter int NBIT       = 32,
  parameter int NBIT_BLOCK = 4
) (
  input logic                         clk,
  input logic                         reset,
  pipelined_block_subtractor_if.slave bus
);
  localparam int BLOCK_NUM = NBIT / NBIT_BLOCK;
  localparam int W         = NBIT_BLOCK;
  localparam int STAGES    = BLOCK_NUM - 1;

  if (NBIT % NBIT_BLOCK != 0) begin : g_chk
    $error("pipelined_block_subtractor: NBIT must be divisible by NBIT_BLOCK");
  end

  // Whole pipeline moves as one; a bubble at the tail still lets it advance.
  logic            adv;
  logic [STAGES:0] vld_pipe;

  assign adv           = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (adv) begin
      for (int k = STAGES; k > 0; k--) vld_pipe[k] <= vld_pipe[k-1];
      vld_pipe[0] <= bus.in_valid;
    end
  end

  // Stage k: res_q holds result slices 0..k with the untouched a slices above
  // them in the same word; g_fwd.b_q keeps only the b slices still to come.
  for (genvar k = 0; k < BLOCK_NUM; k++) begin : stg
    logic [NBIT-1:0]   op_a, res_d, res_q;
    logic [NBIT-1:k*W] b_in;
    logic [W-1:0]      s;
    logic              cin, cout, c_q;

    if (k == 0) begin : g_src
      assign op_a = bus.a;
      assign b_in = bus.b;
      assign cin  = 1'b1;
    end else begin : g_src
      assign op_a = stg[k-1].res_q;
      assign b_in = stg[k-1].g_fwd.b_q;
      assign cin  = stg[k-1].c_q;
    end

    pbs_slice #(.W(W)) u_slice (
      .a   (op_a[k*W +: W]),
      .b   (b_in[k*W +: W]),
      .cin (cin),
      .s   (s),
      .cout(cout)
    );

    always_comb begin
      res_d           = op_a;
      res_d[k*W +: W] = s;
    end

    // Final carry resets to 1 so that borrow (its inverse) reads 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q <= '0;
        c_q   <= (k == STAGES);
      end else if (adv) begin
        res_q <= res_d;
        c_q   <= cout;
      end
    end

    if (k < STAGES) begin : g_fwd
      logic [NBIT-1:(k+1)*W] b_q;
      always_ff @(posedge clk) begin
        if (reset)    b_q <= '0;
        else if (adv) b_q <= b_in[NBIT-1:(k+1)*W];
      end
    end

`ifdef PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN
    // The a and b sign bits reach the last stage untouched inside op_a/b_in.
    if (k == STAGES) begin : g_flg
      logic ovf_q, zero_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (op_a[NBIT-1] ^ b_in[NBIT-1]) & (res_d[NBIT-1] ^ op_a[NBIT-1]);
          zero_q <= (res_d == '0);
        end
      end
    end
`endif
  end

  assign bus.d      = stg[STAGES].res_q;
  assign bus.borrow = ~stg[STAGES].c_q;
`ifdef PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN
  assign bus.ovf    = stg[STAGES].g_flg.ovf_q;
  assign bus.zero   = stg[STAGES].g_flg.zero_q;
`endif
endmodule

// File: tb/tb_pipelined_block_subtractor.sv
// tb_pipelined_block_subtractor
//   Scoreboard bench: the driver pushes expected results when a transfer is
//   accepted, a negedge monitor compares whenever out_valid is high.
//   Main DUT: NBIT=32/NBIT_BLOCK=4. Sweep DUTs: NBIT=8, NBIT_BLOCK 1/2/4/8,
//   exhaustive operands on their own reset.
module tb_pipelined_block_subtractor;
  logic clk = 1'b0;
  logic reset, sw_reset;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   rst_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- main DUT ----------------
  pipelined_block_subtractor_if #(.NBIT(32)) bus();
  pipelined_block_subtractor #(.NBIT(32), .NBIT_BLOCK(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        br, ov, zr;
    int          issue;
    bit          lat;
    bit          seen;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected result: d=%h with nothing pending", bus.d);
        end else begin
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            if (sb[0].lat) chk("latency", cyc - sb[0].issue, 8);
          end
          chk("d", bus.d, sb[0].d);
          chk("borrow", bus.borrow, sb[0].br);
`ifdef PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN
          chk("ovf", bus.ovf, sb[0].ov);
          chk("zero", bus.zero, sb[0].zr);
`endif
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ai, bi, ed, input logic eb, eo, ez, input bit lat);
    bus.a = ai; bus.b = bi; bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{ed, eb, eo, ez, cyc, lat, 1'b0});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept: in_ready never rose for a=%h b=%h", ai, bi);
  endtask

  task automatic sendm(input logic [31:0] ai, bi, input bit lat);
    logic [31:0] dd;
    dd = ai - bi;
    send(ai, bi, dd, ai < bi, (ai[31] != bi[31]) && (dd[31] != ai[31]), dd == 0, lat);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    chk("drain pending", sb.size(), 0);
    #1;
  endtask

  // ---------------- NBIT=8 sweep ----------------
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int NB = 1 << g;
    typedef struct { logic [8:0] r; int issue; } se_t;
    se_t q[$];
    bit  done = 1'b0;

    pipelined_block_subtractor_if #(.NBIT(8)) sif();
    pipelined_block_subtractor #(.NBIT(8), .NBIT_BLOCK(NB)) u (
      .clk(clk), .reset(sw_reset), .bus(sif)
    );

    initial begin
      sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.out_ready = 1'b1;
      wait (rst_done);
      @(posedge clk); #1;
      for (int i = 0; i < 65536; i++) begin
        sif.a = i[15:8]; sif.b = i[7:0]; sif.in_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("sweep%0d in_ready", NB), sif.in_ready, 1);
        q.push_back('{{1'b0, sif.a} - {1'b0, sif.b}, cyc});
        @(posedge clk); #1;
      end
      sif.in_valid = 1'b0;
      for (int n = 0; n < 30 && q.size() != 0; n++) @(posedge clk);
      chk($sformatf("sweep%0d drain", NB), q.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!sw_reset && sif.out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sweep%0d unexpected result d=%h", NB, sif.d);
        end else begin
          se_t e;
          e = q.pop_front();
          chk($sformatf("sweep%0d {borrow,d}", NB), {sif.borrow, sif.d}, e.r);
          chk($sformatf("sweep%0d latency", NB), cyc - e.issue, 8 / NB);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    reset = 1'b1; sw_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; sw_reset = 1'b0; rst_done = 1'b1;

    @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset d", bus.d, 0);
    chk("reset borrow", bus.borrow, 0);
    chk("reset in_ready", bus.in_ready, 1);
`ifdef PIPELINED_BLOCK_SUBTRACTOR_FLAGS_EN
    chk("reset ovf", bus.ovf, 0);
    chk("reset zero", bus.zero, 0);
`endif
    @(posedge clk); #1;

    // Basic subtract with latency check.
    send(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Full borrow chain, signed overflow, zero result, back to back.
    send(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // 20-pair stream with a 5-cycle consumer stall in the middle.
    fork
      for (int i = 0; i < 20; i++) sendm($urandom, $urandom, 1'b0);
      begin
        repeat (12) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 5 transactions in flight: they must never appear.
    for (int i = 0; i < 5; i++) sendm(32'h100 + i, 32'h3, 1'b0);
    reset = 1'b1; bus.in_valid = 1'b0; sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("flush out_valid", bus.out_valid, 0);
    chk("flush d", bus.d, 0);
    chk("flush borrow", bus.borrow, 0);
    repeat (12) @(posedge clk);
    #1;
    send(32'h0000_0055, 32'h0000_0022, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    for (int n = 0; n < 80000 && !(sw[0].done && sw[1].done && sw[2].done && sw[3].done); n++)
      @(posedge clk);
    chk("sweep complete", {sw[3].done, sw[2].done, sw[1].done, sw[0].done}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
